// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver with optional even/odd parity.
//               Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    localparam int BCW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [BCW-1:0] c_LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic [2:0]            state_q,    state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [5:0]            pre_q,      pre_d;
    logic                  pen_q,      pen_d;
    logic                  ptyp_q,     ptyp_d;
    logic                  par_err_q,  par_err_d;
    logic [DATA_WIDTH-1:0] pdata_q,    pdata_d;
    logic                  dv_q,       dv_d;
    logic                  pe_q,       pe_d;
    logic                  se_q,       se_d;

    logic [5:0]            w_half;
    logic                  w_last_edge;
    logic                  w_samp_edge;
    logic                  w_bit;
    logic                  w_exp_par;
    logic [DATA_WIDTH:0]   w_shift_in;

    assign w_half      = {1'b0, pre_q[5:1]};
    assign w_last_edge = (edge_cnt_q == pre_q - 6'd1);
    assign w_exp_par   = ptyp_q ? ~^shift_q : ^shift_q;
    assign w_shift_in  = {w_bit, shift_q};

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Two early samples are held; the third is the live line at half+1.
    logic samp0_q, samp1_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp0_q <= 1'b1;
            samp1_q <= 1'b1;
        end else begin
            if (edge_cnt_q == w_half - 6'd1) samp0_q <= RX_IN;
            if (edge_cnt_q == w_half)        samp1_q <= RX_IN;
        end
    end

    assign w_samp_edge = (edge_cnt_q == w_half + 6'd1);
    assign w_bit       = (samp0_q & samp1_q) | (samp0_q & RX_IN) | (samp1_q & RX_IN);
`else
    assign w_samp_edge = (edge_cnt_q == w_half);
    assign w_bit       = RX_IN;
`endif

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = w_last_edge ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pre_d      = pre_q;
        pen_d      = pen_q;
        ptyp_d     = ptyp_q;
        par_err_d  = par_err_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        case (state_q)
            c_IDLE: begin
                edge_cnt_d = 6'd0;
                bit_cnt_d  = '0;
                // The cycle that sees the falling edge is edge_cnt 0 of the start bit.
                if (!RX_IN) begin
                    state_d    = c_START;
                    edge_cnt_d = 6'd1;
                    pre_d      = Prescale;
                    pen_d      = PAR_EN;
                    ptyp_d     = PAR_TYP;
                    par_err_d  = 1'b0;
                end
            end
            c_START: begin
                if (w_samp_edge && w_bit) begin
                    state_d    = c_IDLE;
                    edge_cnt_d = 6'd0;
                end else if (w_last_edge) begin
                    state_d   = c_DATA;
                    bit_cnt_d = '0;
                end
            end
            c_DATA: begin
                if (w_samp_edge) shift_d = w_shift_in[DATA_WIDTH:1];
                if (w_last_edge) begin
                    if (bit_cnt_q == c_LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = pen_q ? c_PARITY : c_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            c_PARITY: begin
                if (w_samp_edge) par_err_d = (w_bit != w_exp_par);
                if (w_last_edge) state_d = c_STOP;
            end
            c_STOP: begin
                // Decide at the sample point and return early so a
                // back-to-back start bit is not missed.
                if (w_samp_edge) begin
                    state_d    = c_IDLE;
                    edge_cnt_d = 6'd0;
                    se_d       = ~w_bit;
                    pe_d       = par_err_q;
                    if (w_bit && !par_err_q) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = c_IDLE;
                edge_cnt_d = 6'd0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= c_IDLE;
            edge_cnt_q <= 6'd0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            pre_q      <= 6'd8;
            pen_q      <= 1'b0;
            ptyp_q     <= 1'b0;
            par_err_q  <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            pre_q      <= pre_d;
            pen_q      <= pen_d;
            ptyp_q     <= ptyp_d;
            par_err_q  <= par_err_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA       = pdata_q;
    assign Data_Valid   = dv_q;
    assign Parity_Error = pe_q;
    assign Stop_Error   = se_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (vector table, corner cases,
//               randomized frames against a frame-level reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid, Parity_Error, Stop_Error;

    int         total = 0;
    int         bad = 0;
    logic [7:0] model_pdata = 8'h00;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .Data_Valid(Data_Valid), .Parity_Error(Parity_Error), .Stop_Error(Stop_Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        logic [7:0] d;
        bit         badp;
        bit         stop;
        bit         dv;
        bit         pe;
        bit         se;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input string nm);
        int spur = 0;
        RX_IN = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (Data_Valid || Parity_Error || Stop_Error) spur++;
            tick();
        end
        chk({nm, "_quiet"}, spur, 0);
    endtask

    // Drives one frame; pulses are expected only at the frame-latency cycle.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit badp, input bit stop,
                              input bit edv, input bit epe, input bit ese, input string nm);
        bit bits[$];
        int n, exp_c, spur;
        bit parb;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        parb = (ptyp ? ~^d : ^d) ^ badp;
        if (pen) bits.push_back(parb);
        bits.push_back(stop);
        n     = bits.size();
        exp_c = (n - 1) * p + p / 2 + 1 + V;
        spur  = 0;
        for (int c = 0; c < n * p; c++) begin
            int b = c / p;
            int k = c % p;
            if (c == 0) begin
                Prescale = 6'(p);
                PAR_EN   = pen;
                PAR_TYP  = ptyp;
            end else if (c == 1) begin
                Prescale = 6'(8 << $urandom_range(0, 2));
                PAR_EN   = 1'($urandom);
                PAR_TYP  = 1'($urandom);
            end
            RX_IN = (b == n - 1 && k > p / 2 + V) ? 1'b1 : bits[b];
            @(negedge CLK);
            if (c == exp_c) begin
                chk({nm, "_dv"}, 32'(Data_Valid), 32'(edv));
                chk({nm, "_pe"}, 32'(Parity_Error), 32'(epe));
                chk({nm, "_se"}, 32'(Stop_Error), 32'(ese));
                if (edv) model_pdata = d;
                chk({nm, "_pdata"}, 32'(P_DATA), 32'(model_pdata));
            end else if (Data_Valid || Parity_Error || Stop_Error) begin
                spur++;
            end
            tick();
        end
        RX_IN = 1'b1;
        chk({nm, "_spurious"}, spur, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{8,  1, 0, 8'hA5, 0, 1, 1, 0, 0};
        tbl[1] = '{8,  1, 0, 8'hA5, 1, 1, 0, 1, 0};
        tbl[2] = '{16, 0, 0, 8'h3C, 0, 0, 0, 0, 1};
        tbl[3] = '{16, 1, 1, 8'h00, 0, 1, 1, 0, 0};
        tbl[4] = '{8,  1, 1, 8'hFF, 1, 0, 0, 1, 1};
        tbl[5] = '{32, 0, 0, 8'h7E, 0, 1, 1, 0, 0};

        repeat (3) tick();
        chk("rst_pdata", 32'(P_DATA), 32'h0);
        chk("rst_dv", 32'(Data_Valid), 32'h0);
        chk("rst_pe", 32'(Parity_Error), 32'h0);
        chk("rst_se", 32'(Stop_Error), 32'h0);
        RST = 1'b1;
        idle(3, "post_rst");

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].p, tbl[i].pen, tbl[i].ptyp, tbl[i].d, tbl[i].badp, tbl[i].stop,
                       tbl[i].dv, tbl[i].pe, tbl[i].se, $sformatf("vec%0d", i));
            idle(3, $sformatf("vec%0d_gap", i));
        end

        // Short low glitch must be rejected as a false start.
        Prescale = 6'd8;
        RX_IN = 1'b0;
        repeat (3) tick();
        idle(40, "glitch");
        send_frame(8, 0, 0, 8'h6B, 0, 1, 1, 0, 0, "after_glitch");

        send_frame(32, 1, 1, 8'h55, 0, 1, 1, 0, 0, "b2b_first");
        send_frame(32, 1, 1, 8'hF0, 0, 1, 1, 0, 0, "b2b_second");
        idle(4, "b2b_gap");

        // Reset in the middle of the data bits.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) tick();
        RX_IN = 1'b1;
        repeat (10) tick();
        #3 RST = 1'b0;
        #1;
        chk("midrst_pdata", 32'(P_DATA), 32'h0);
        chk("midrst_dv", 32'(Data_Valid), 32'h0);
        chk("midrst_pe", 32'(Parity_Error), 32'h0);
        chk("midrst_se", 32'(Stop_Error), 32'h0);
        model_pdata = 8'h00;
        tick();
        repeat (2) tick();
        RST = 1'b1;
        idle(5, "midrst_idle");
        send_frame(8, 0, 0, 8'h81, 0, 1, 1, 0, 0, "midrst_next");

        for (int i = 0; i < 25; i++) begin
            int         p    = 8 << $urandom_range(0, 2);
            bit         pen  = 1'($urandom);
            bit         ptyp = 1'($urandom);
            logic [7:0] d    = 8'($urandom);
            bit         badp = ($urandom_range(0, 3) == 0);
            bit         stop = ($urandom_range(0, 4) != 0);
            bit         epe  = pen && badp;
            send_frame(p, pen, ptyp, d, badp, stop, stop && !epe, epe, !stop,
                       $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 5), $sformatf("rnd%0d_gap", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
